// File: rtl/timer_pkg.sv
// Shared types and defaults for the game-clock datapath and its controller bench.
package timer_pkg;

  typedef logic [3:0] bcd_t;

  typedef enum logic [2:0] {
    IDLE,
    CMP,
    WRITE,
    HOLD,
    ACK
  } save_state_e;

  localparam bcd_t START_TENS_DEF = 4'd6;
  localparam bcd_t START_ONES_DEF = 4'd0;
  localparam bcd_t BCD_MAX        = 4'd9;

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD down-counting digit: load, decrement, and at zero either wrap to 9 or hold.
module bcd_down_digit
  import timer_pkg::*;
#(
  parameter bcd_t RST_VAL = 4'd0,
  parameter bit   WRAP    = 1'b0
) (
  input  logic clk,
  input  logic resetn,
  input  logic load,
  input  bcd_t load_val,
  input  logic dec,
  input  logic no_wrap,
  output bcd_t value,
  output logic zero_c
);

  assign zero_c = (value == 4'd0);

  // Load wins over decrement; a floor digit (or a suppressed wrap) sticks at 0.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      value <= RST_VAL;
    end else if (load) begin
      value <= load_val;
    end else if (dec) begin
      if (!zero_c) begin
        value <= value - 4'd1;
      end else if (WRAP && !no_wrap) begin
        value <= BCD_MAX;
      end
    end
  end

endmodule

// File: rtl/timer_datapath.sv
// Two-digit BCD game clock with borrow/expiry flags and the high-score save sequence.
module timer_datapath
  import timer_pkg::*;
#(
  parameter bcd_t        START_TENS = START_TENS_DEF,
  parameter bcd_t        START_ONES = START_ONES_DEF,
  parameter int unsigned SCORE_W    = 8,
  parameter int unsigned SAVE_HOLD  = 25000000
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               ld_wait,
  input  logic               ld_set,
  input  logic               ld_one,
  input  logic               ld_ten,
  input  logic [SCORE_W-1:0] score,
  output logic               changeTen,
  output logic               done,
  output logic               doneSave,
  output bcd_t               tens,
  output bcd_t               ones,
  output logic [SCORE_W-1:0] high_score,
  output logic               hs_we
);

  localparam int unsigned      CNT_W    = (SAVE_HOLD > 1) ? $clog2(SAVE_HOLD) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAVE_HOLD - 1);

  logic             load_c;
  logic             ten_dec_c;
  logic             one_dec_c;
  logic             tens_zero_c;
  logic             ones_zero_c;
  logic             done_q;
  save_state_e      state;
  logic [CNT_W-1:0] cnt;

  // Strobe priority: ld_wait > ld_set > ld_ten > ld_one.
  assign load_c    = ld_wait | ld_set;
  assign ten_dec_c = ~load_c & ld_ten;
  assign one_dec_c = ~load_c & ~ld_ten & ld_one;

  bcd_down_digit #(.RST_VAL(START_TENS), .WRAP(1'b0)) u_tens (
    .clk      (clk),
    .resetn   (resetn),
    .load     (load_c),
    .load_val (START_TENS),
    .dec      (ten_dec_c),
    .no_wrap  (1'b1),
    .value    (tens),
    .zero_c   (tens_zero_c)
  );

  // Ones wraps to 9 on a borrow unless the whole clock is already at 00.
  bcd_down_digit #(.RST_VAL(START_ONES), .WRAP(1'b1)) u_ones (
    .clk      (clk),
    .resetn   (resetn),
    .load     (load_c),
    .load_val (START_ONES),
    .dec      (one_dec_c),
    .no_wrap  (tens_zero_c),
    .value    (ones),
    .zero_c   (ones_zero_c)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      changeTen <= 1'b0;
      done      <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= done;
      if (load_c) begin
        changeTen <= 1'b0;
        done      <= 1'b0;
      end else if (ten_dec_c) begin
        changeTen <= 1'b0;
      end else if (one_dec_c) begin
        changeTen <= ones_zero_c;
        if (ones_zero_c && tens_zero_c) begin
          done <= 1'b1;
        end
      end
    end
  end

  // Save sequence: compare, optional single-cycle write, hold, then acknowledge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      cnt        <= '0;
      high_score <= '0;
      hs_we      <= 1'b0;
      doneSave   <= 1'b0;
    end else begin
      hs_we    <= 1'b0;
      doneSave <= (state == ACK) && !ld_wait;
      if (ld_wait) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (done && !done_q) begin
              state <= CMP;
            end
          end
          CMP: begin
            cnt   <= '0;
            state <= (score > high_score) ? WRITE : HOLD;
          end
          WRITE: begin
            high_score <= score;
            hs_we      <= 1'b1;
            cnt        <= '0;
            state      <= HOLD;
          end
          HOLD: begin
            if (cnt == CNT_LAST) begin
              state <= ACK;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          ACK:     state <= ACK;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
